// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the 64x16 program/data RAM and its write-side loader.
// Holds the RAM geometry and the loader state encoding.
package cpu_mem_pkg;

  localparam int RAM_ADDR_W = 6;
  localparam int RAM_DATA_W = 16;
  localparam int BYTE_W     = 8;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_HI    = 3'd1,
    LD_LO    = 3'd2,
    LD_WRITE = 3'd3,
    LD_DONE  = 3'd4
  } loader_state_e;

endpackage

// File: rtl/ram_loader.sv
// Packs a valid/ready byte stream high-byte-first into 16-bit words and writes
// them to consecutive RAM addresses from a latched start address.
module ram_loader #(
  parameter int ADDR_W = cpu_mem_pkg::RAM_ADDR_W,
  parameter int BYTE_W = cpu_mem_pkg::BYTE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W:0]     length,
  input  logic                in_valid,
  input  logic [BYTE_W-1:0]   in_data,
  output logic                in_ready,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [2*BYTE_W-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     word_count
);

  import cpu_mem_pkg::*;

  loader_state_e       state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [BYTE_W-1:0]   hi_q, hi_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [2*BYTE_W-1:0] wr_data_q, wr_data_d;
  logic                in_ready_q, wr_en_q, busy_q, done_q;

  logic accept;
  assign accept = in_valid && in_ready_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    count_d   = count_q;
    hi_d      = hi_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      LD_IDLE: begin
        if (start) begin
          addr_d  = start_addr;
          len_d   = length;
          count_d = '0;
          state_d = (length == '0) ? LD_DONE : LD_HI;
        end
      end
      LD_HI: begin
        if (accept) begin
          hi_d    = in_data;
          state_d = LD_LO;
        end
      end
      LD_LO: begin
        if (accept) begin
          wr_data_d = {hi_q, in_data};
          wr_addr_d = addr_q;
          state_d   = LD_WRITE;
        end
      end
      LD_WRITE: begin
        // The address wraps naturally at 2**ADDR_W.
        addr_d  = addr_q + 1'b1;
        count_d = count_q + 1'b1;
        state_d = (count_d == len_q) ? LD_DONE : LD_HI;
      end
      LD_DONE: state_d = LD_IDLE;
      default: state_d = LD_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LD_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      count_q    <= '0;
      hi_q       <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      in_ready_q <= (state_d == LD_HI) || (state_d == LD_LO);
      wr_en_q    <= (state_d == LD_WRITE);
      busy_q     <= (state_d != LD_IDLE);
      done_q     <= (state_d == LD_DONE);
    end
  end

  assign in_ready   = in_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: expected RAM writes are queued when a
// load is started and compared as wr_en pulses appear.
module tb_ram_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  start_addr;
  logic [6:0]  length;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic [6:0]  word_count;

  ram_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  wr_cnt = 0;
  int  done_cnt = 0;
  int  ready_cnt = 0;

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst === 1'b0) begin
      if (wr_en) begin
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if (wr_addr !== e.addr || wr_data !== e.data) begin
            errors++;
            $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                     wr_addr, wr_data, e.addr, e.data);
          end
        end
      end
      if (done) done_cnt++;
      if (in_ready) ready_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    wr_cnt = 0;
    done_cnt = 0;
    ready_cnt = 0;
  endtask

  task automatic do_start(input logic [5:0] a, input logic [6:0] l);
    start = 1'b1;
    start_addr = a;
    length = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data = b;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc, input logic [6:0] exp_wc);
    int n = 0;
    @(negedge clk);
    while (!done && n < max_cyc) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%b after %0d cycles, expected 1", name, done, n);
    end
    checks++;
    if (word_count !== exp_wc) begin
      errors++;
      $display("FAIL %s_word_count: got %0d, expected %0d", name, word_count, exp_wc);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_done: busy=%b done=%b, expected 0 0", name, busy, done);
    end
    checks++;
    if (word_count !== exp_wc) begin
      errors++;
      $display("FAIL %s_word_count_hold: got %0d, expected %0d", name, word_count, exp_wc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_end(input string name, input int exp_wr);
    checks++;
    if (wr_cnt !== exp_wr || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_writes: got %0d writes (%0d pending), expected %0d (0 pending)",
               name, wr_cnt, exp_q.size(), exp_wr);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL %s_done_pulses: got %0d, expected 1", name, done_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    start_addr = '0;
    length = '0;
    in_valid = 1'b0;
    in_data = '0;
    #12;
    checks++;
    if ({in_ready, wr_en, busy, done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready/wr_en/busy/done=%b, expected 0000", {in_ready, wr_en, busy, done});
    end
    checks++;
    if (wr_addr !== 6'd0 || wr_data !== 16'h0 || word_count !== 7'd0) begin
      errors++;
      $display("FAIL reset_data: wr_addr=%0d wr_data=%h word_count=%0d, expected 0 0000 0",
               wr_addr, wr_data, word_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    clear_counts();
    exp_q.push_back('{addr: 6'd0, data: 16'h1234});
    exp_q.push_back('{addr: 6'd1, data: 16'hABCD});
    do_start(6'd0, 7'd2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b, expected 1", busy);
    end
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAB);
    send_byte(8'hCD);
    wait_done("basic", 20, 7'd2);
    check_end("basic", 2);
  endtask

  task automatic test_wrap();
    clear_counts();
    exp_q.push_back('{addr: 6'd62, data: 16'h0001});
    exp_q.push_back('{addr: 6'd63, data: 16'h0203});
    exp_q.push_back('{addr: 6'd0,  data: 16'h0405});
    exp_q.push_back('{addr: 6'd1,  data: 16'h0607});
    do_start(6'd62, 7'd4);
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    wait_done("wrap", 20, 7'd4);
    check_end("wrap", 4);
  endtask

  task automatic test_zero_len();
    clear_counts();
    do_start(6'd7, 7'd0);
    wait_done("zero", 3, 7'd0);
    check_end("zero", 0);
    checks++;
    if (ready_cnt !== 0) begin
      errors++;
      $display("FAIL zero_in_ready: in_ready high %0d cycles, expected 0", ready_cnt);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] bytes [2];
    int idx = 0;
    logic fire;
    bytes[0] = 8'hDE;
    bytes[1] = 8'hAD;
    clear_counts();
    exp_q.push_back('{addr: 6'd33, data: 16'hDEAD});
    do_start(6'd33, 7'd1);
    for (int c = 0; c < 40 && idx < 2; c++) begin
      in_valid = c[0];
      in_data = bytes[idx];
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (fire) idx++;
    end
    in_valid = 1'b0;
    checks++;
    if (idx !== 2) begin
      errors++;
      $display("FAIL gaps_consumed: got %0d bytes, expected 2", idx);
    end
    wait_done("gaps", 10, 7'd1);
    check_end("gaps", 1);
    // A byte offered while idle must not be taken.
    clear_counts();
    in_valid = 1'b1;
    in_data = 8'hFF;
    repeat (3) tick();
    in_valid = 1'b0;
    checks++;
    if (ready_cnt !== 0 || wr_cnt !== 0) begin
      errors++;
      $display("FAIL idle_no_consume: in_ready cycles=%0d writes=%0d, expected 0 0", ready_cnt, wr_cnt);
    end
  endtask

  task automatic test_reset_mid();
    clear_counts();
    do_start(6'd40, 7'd3);
    send_byte(8'h11);
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, wr_en, busy, done} !== 4'b0 || wr_addr !== 6'd0 || wr_data !== 16'h0 || word_count !== 7'd0) begin
      errors++;
      $display("FAIL reset_mid: ctrl=%b wr_addr=%0d wr_data=%h word_count=%0d, expected all 0",
               {in_ready, wr_en, busy, done}, wr_addr, wr_data, word_count);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (wr_cnt !== 0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: writes=%0d in_ready=%b busy=%b, expected 0 0 0", wr_cnt, in_ready, busy);
    end
    clear_counts();
    exp_q.push_back('{addr: 6'd20, data: 16'h5566});
    do_start(6'd20, 7'd1);
    send_byte(8'h55);
    send_byte(8'h66);
    wait_done("after_reset", 10, 7'd1);
    check_end("after_reset", 1);
  endtask

  task automatic test_start_busy();
    clear_counts();
    exp_q.push_back('{addr: 6'd5, data: 16'hA1B2});
    exp_q.push_back('{addr: 6'd6, data: 16'hC3D4});
    do_start(6'd5, 7'd2);
    send_byte(8'hA1);
    do_start(6'd10, 7'd1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    wait_done("start_busy", 20, 7'd2);
    check_end("start_busy", 2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_len();
    test_gaps();
    test_reset_mid();
    test_start_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
